// File: rtl/pc_redirect_unit.sv
// Fetch PC owner for the MIPS core: applies ID-stage branch/jump redirects after the delay slot.
// Optional branch statistics counters are enabled with the BRANCH_STATS_EN macro.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        id_valid,
    input  logic        is_br,
    input  logic        br_taken,
    input  logic        is_jump_imm,
    input  logic        is_jump_reg,
    input  logic [31:0] id_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic        pending,
    output logic [31:0] br_total,
    output logic [31:0] br_taken_cnt
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pendTarget_q;
    logic        pending_q;
    logic        redirect_q;

    logic [31:0] idPcPlus4;
    logic [31:0] branchOffset;
    logic        take;
    logic [31:0] target;

    assign idPcPlus4    = id_pc + 32'd4;
    assign branchOffset = {{14{imm16[15]}}, imm16, 2'b00};
    assign take         = id_valid & ~stall & (is_jump_reg | is_jump_imm | (is_br & br_taken));
    assign link_addr    = id_pc + 32'd8;

    // Illegal multi-source decisions fall out of the priority order here.
    always_comb begin
        target = idPcPlus4 + branchOffset;
        if (is_jump_reg) begin
            target = jr_target;
        end else if (is_jump_imm) begin
            target = {idPcPlus4[31:28], instr_index, 2'b00};
        end
    end

    // In HOLD the delay slot is being fetched at the old PC; the buffered target follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pendTarget_q <= 32'h0;
            pending_q    <= 1'b0;
            redirect_q   <= 1'b0;
        end else begin
            redirect_q <= take;
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        if (fetch_ready) begin
                            pc_q <= take ? target : pc_q + 32'd4;
                        end else if (take) begin
                            pendTarget_q <= target;
                            pending_q    <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (fetch_ready) begin
                        pc_q      <= pendTarget_q;
                        pending_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign pc_out   = pc_q;
    assign pending  = pending_q;
    assign redirect = redirect_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] brTotal_q;
    logic [31:0] brTaken_q;
    logic        brAccepted;

    assign brAccepted = id_valid & ~stall & is_br;

    always_ff @(posedge clk) begin
        if (reset) begin
            brTotal_q <= 32'h0;
            brTaken_q <= 32'h0;
        end else if (brAccepted) begin
            brTotal_q <= brTotal_q + 32'd1;
            if (br_taken) begin
                brTaken_q <= brTaken_q + 32'd1;
            end
        end
    end

    assign br_total     = brTotal_q;
    assign br_taken_cnt = brTaken_q;
`else
    assign br_total     = 32'h0;
    assign br_taken_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: a behavioural model predicts each cycle's outputs,
// and a negedge monitor compares them against the DUT.
module tb_pc_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, fetchReady, idValid, isBr, brTaken, isJumpImm, isJumpReg;
    logic [31:0] idPc, jrTarget;
    logic [15:0] imm16;
    logic [25:0] instrIndex;
    logic [31:0] pcOut, linkAddr, brTotal, brTakenCnt;
    logic        redirect, pending;

    pc_redirect_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetchReady),
        .id_valid(idValid), .is_br(isBr), .br_taken(brTaken),
        .is_jump_imm(isJumpImm), .is_jump_reg(isJumpReg),
        .id_pc(idPc), .imm16(imm16), .instr_index(instrIndex), .jr_target(jrTarget),
        .pc_out(pcOut), .link_addr(linkAddr), .redirect(redirect), .pending(pending),
        .br_total(brTotal), .br_taken_cnt(brTakenCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        pend;
        logic        red;
        logic [31:0] tot;
        logic [31:0] tk;
        logic [31:0] link;
    } expect_t;

    expect_t     sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mPc = RST_PC;
    logic [31:0] mBuf = 32'h0;
    logic        mPend = 1'b0;
    logic        mRed = 1'b0;
    logic [31:0] mTot = 32'h0;
    logic [31:0] mTk = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // Target rules written as plain arithmetic on the instruction fields.
    function automatic logic [31:0] refTarget();
        int off;
        if (isJumpReg) return jrTarget;
        if (isJumpImm) return ((idPc + 32'd4) & 32'hF000_0000) | (32'(instrIndex) * 32'd4);
        off = int'($signed(imm16));
        return idPc + 32'd4 + 32'(off * 4);
    endfunction

    task automatic modelStep();
        logic        tk;
        logic [31:0] t;
        expect_t     e;
        tk = idValid & ~stall & (isJumpReg | isJumpImm | (isBr & brTaken));
        t  = refTarget();
        if (reset) begin
            mPc = RST_PC; mPend = 1'b0; mBuf = 32'h0; mRed = 1'b0; mTot = 0; mTk = 0;
        end else begin
`ifdef BRANCH_STATS_EN
            if (idValid && !stall && isBr) begin
                mTot = mTot + 1;
                if (brTaken) mTk = mTk + 1;
            end
`endif
            if (mPend) begin
                if (fetchReady) begin
                    mPc = mBuf; mPend = 1'b0;
                end
            end else if (!stall) begin
                if (fetchReady) mPc = tk ? t : mPc + 32'd4;
                else if (tk) begin
                    mBuf = t; mPend = 1'b1;
                end
            end
            mRed = tk;
        end
        e.pc = mPc; e.pend = mPend; e.red = mRed; e.tot = mTot; e.tk = mTk; e.link = 32'h0;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, predict the post-edge state, and advance past the edge.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle(input logic fr);
        reset = 1'b0; stall = 1'b0; fetchReady = fr; idValid = 1'b0;
        isBr = 1'b0; brTaken = 1'b0; isJumpImm = 1'b0; isJumpReg = 1'b0;
    endtask

    task automatic setCtl(input logic br, input logic bt, input logic ji, input logic jr);
        idValid = 1'b1; isBr = br; brTaken = bt; isJumpImm = ji; isJumpReg = jr;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("pc_out", pcOut, e.pc);
            checkOutput("pending", {31'h0, pending}, {31'h0, e.pend});
            checkOutput("redirect", {31'h0, redirect}, {31'h0, e.red});
            checkOutput("br_total", brTotal, e.tot);
            checkOutput("br_taken_cnt", brTakenCnt, e.tk);
            checkOutput("link_addr", linkAddr, idPc + 32'd8);
        end
    end

    initial begin
        idPc = 32'h0; imm16 = 16'h0; instrIndex = 26'h0; jrTarget = 32'h0;
        setIdle(1'b1);
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_pc", pcOut, RST_PC);
        checkOutput("reset_pending", {31'h0, pending}, 32'h0);

        setIdle(1'b1);
        repeat (3) applyStimulus();
        checkOutput("free_run_pc", pcOut, 32'h0000_300C);

        idPc = 32'h3004; imm16 = 16'hFFFE;
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("br_taken_pc", pcOut, 32'h0000_3000);
        checkOutput("br_taken_redirect", {31'h0, redirect}, 32'h1);
        setIdle(1'b1);
        applyStimulus();
        checkOutput("redirect_one_cycle", {31'h0, redirect}, 32'h0);

        setCtl(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("br_not_taken_pc", pcOut, 32'h0000_3008);

        idPc = 32'h3010; instrIndex = 26'h0000C10;
        setCtl(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("jal_pc", pcOut, 32'h0000_3040);
        checkOutput("jal_link", linkAddr, 32'h0000_3018);

        jrTarget = 32'h0000_4000;
        setCtl(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("jr_pc", pcOut, 32'h0000_4000);

        idPc = 32'h4000; imm16 = 16'h0010;
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        applyStimulus();
        checkOutput("stall_pc_hold", pcOut, 32'h0000_4000);
        stall = 1'b0; fetchReady = 1'b0;
        applyStimulus();
        checkOutput("hold_pending", {31'h0, pending}, 32'h1);
        setIdle(1'b0);
        repeat (3) applyStimulus();
        checkOutput("hold_pc", pcOut, 32'h0000_4000);
        fetchReady = 1'b1;
        applyStimulus();
        checkOutput("hold_release_pc", pcOut, 32'h0000_4044);

        jrTarget = 32'hFFFF_FFFC;
        setCtl(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        setIdle(1'b1);
        applyStimulus();
        checkOutput("wrap_pc", pcOut, 32'h0000_0000);

        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        fetchReady = 1'b0;
        applyStimulus();
        setIdle(1'b0);
        reset = 1'b1;
        applyStimulus();
        checkOutput("reset_in_hold_pc", pcOut, RST_PC);
        checkOutput("reset_in_hold_pending", {31'h0, pending}, 32'h0);

        setIdle(1'b1);
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        setCtl(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus();
`ifdef BRANCH_STATS_EN
        checkOutput("stats_total", brTotal, 32'd3);
        checkOutput("stats_taken", brTakenCnt, 32'd2);
`else
        checkOutput("stats_total_off", brTotal, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            int sel;
            setIdle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            reset     = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 9) < 2);
            idPc      = $urandom() & 32'hFFFF_FFFC;
            imm16     = 16'($urandom());
            instrIndex = 26'($urandom());
            jrTarget  = $urandom();
            sel       = $urandom_range(0, 5);
            if (!mPend && $urandom_range(0, 9) < 8) begin
                case (sel)
                    0: setCtl(1'b1, 1'b1, 1'b0, 1'b0);
                    1: setCtl(1'b1, 1'b0, 1'b0, 1'b0);
                    2: setCtl(1'b0, 1'b0, 1'b1, 1'b0);
                    3: setCtl(1'b0, 1'b0, 1'b0, 1'b1);
                    4: setCtl(1'b1, 1'($urandom()), 1'b1, 1'($urandom()));
                    default: setCtl(1'b0, 1'b0, 1'b0, 1'b0);
                endcase
            end
            applyStimulus();
        end

        setIdle(1'b1);
        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
